// File: rtl/vball_gfx_arb.sv
// vball_gfx_arb
// Shares the single graphics ROM read port between the background tile
// fetcher and the sprite fetcher.
//
// Background side: level-held read with an address tag. The last result is
//   cached under its address. bg_valid is combinational and rises whenever the
//   held address matches the cached tag.
// Sprite side: req/ack handshake. spr_ack is a one-cycle pulse with spr_data.
// ROM side: mem_rd is held high with a stable mem_addr until mem_ack arrives,
//   or until TIMEOUT cycles pass. A timeout aborts the read and sets the
//   sticky mem_timeout flag.
//
// Ports
//   clk_sys                  system clock, rising edge
//   rst_n                    synchronous active-low reset
//   bg_addr/bg_read          background request (level)
//   bg_data/bg_valid         cached background result / hit indication
//   spr_addr/spr_req         sprite request (held until spr_ack)
//   spr_ack/spr_data         sprite completion pulse and data
//   mem_addr/mem_rd          ROM read request
//   mem_ack/mem_data         ROM completion pulse and data
//   mem_timeout              sticky ROM timeout error
module vball_gfx_arb #(
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [AW-1:0] bg_addr,
  input  logic          bg_read,
  output logic [DW-1:0] bg_data,
  output logic          bg_valid,
  input  logic [AW-1:0] spr_addr,
  input  logic          spr_req,
  output logic          spr_ack,
  output logic [DW-1:0] spr_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic          mem_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The final waiting cycle is the one where the counter holds TIMEOUT-1,
  // so mem_rd stays high for exactly TIMEOUT cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BG_WAIT  = 2'd1,
    SPR_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] bg_tag;
  logic          tag_v;
  logic [CW-1:0] cnt;
  logic          spr_block;

  logic tag_hit;
  logic bg_pend;
  logic spr_pend;

  assign tag_hit  = tag_v && (bg_tag == bg_addr);
  assign bg_pend  = bg_read && !tag_hit;
  // spr_block masks the cycle right after an ack, when the requester is
  // still dropping spr_req, so no duplicate sprite read is issued.
  assign spr_pend = spr_req && !spr_block;
  assign bg_valid = bg_read && tag_hit;

  // Arbitration FSM with all registered outputs.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_rd      <= 1'b0;
      mem_addr    <= {AW{1'b0}};
      cur_addr    <= {AW{1'b0}};
      bg_tag      <= {AW{1'b0}};
      tag_v       <= 1'b0;
      bg_data     <= {DW{1'b0}};
      spr_data    <= {DW{1'b0}};
      spr_ack     <= 1'b0;
      mem_timeout <= 1'b0;
      cnt         <= {CW{1'b0}};
      spr_block   <= 1'b0;
    end else begin
      spr_ack <= 1'b0;
      case (state)
        IDLE: begin
          spr_block <= 1'b0;
          cnt       <= {CW{1'b0}};
          // Background has strict priority, so it can never be starved.
          if (bg_pend) begin
            mem_addr <= bg_addr;
            cur_addr <= bg_addr;
            mem_rd   <= 1'b1;
            state    <= BG_WAIT;
          end else if (spr_pend) begin
            mem_addr <= spr_addr;
            mem_rd   <= 1'b1;
            state    <= SPR_WAIT;
          end else begin
            mem_rd <= 1'b0;
          end
        end
        BG_WAIT: begin
          // The result is stored under the address that was issued. If bg_addr
          // has moved on, the tag misses and IDLE issues a fresh read.
          if (mem_ack) begin
            bg_data <= mem_data;
            bg_tag  <= cur_addr;
            tag_v   <= 1'b1;
            mem_rd  <= 1'b0;
            cnt     <= {CW{1'b0}};
            state   <= IDLE;
          end else if (cnt == CNT_LAST) begin
            bg_data     <= {DW{1'b0}};
            tag_v       <= 1'b0;
            mem_rd      <= 1'b0;
            mem_timeout <= 1'b1;
            cnt         <= {CW{1'b0}};
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SPR_WAIT: begin
          if (mem_ack) begin
            spr_data  <= mem_data;
            spr_ack   <= 1'b1;
            spr_block <= 1'b1;
            mem_rd    <= 1'b0;
            cnt       <= {CW{1'b0}};
            state     <= IDLE;
          end else if (cnt == CNT_LAST) begin
            // Complete the handshake with zero data so the requester never hangs.
            spr_data    <= {DW{1'b0}};
            spr_ack     <= 1'b1;
            spr_block   <= 1'b1;
            mem_rd      <= 1'b0;
            mem_timeout <= 1'b1;
            cnt         <= {CW{1'b0}};
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          cnt    <= {CW{1'b0}};
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vball_gfx_arb.sv
// Bench for vball_gfx_arb.
// - ROM responder: a ROM whose contents are a fixed function of the address,
//   with a selectable ack latency.
// - Reference model: tag cache and request ordering kept as plain variables.
//   Expected ROM addresses and sprite results go into queues.
// - Monitors: pop the queues and compare whenever the DUT presents
//   mem_rd, spr_ack or bg_valid.
module tb_vball_gfx_arb;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] bg_addr = '0;
  logic          bg_read = 1'b0;
  logic [DW-1:0] bg_data;
  logic          bg_valid;
  logic [AW-1:0] spr_addr = '0;
  logic          spr_req = 1'b0;
  logic          spr_ack;
  logic [DW-1:0] spr_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_timeout;

  vball_gfx_arb #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .bg_addr(bg_addr), .bg_read(bg_read), .bg_data(bg_data), .bg_valid(bg_valid),
    .spr_addr(spr_addr), .spr_req(spr_req), .spr_ack(spr_ack), .spr_data(spr_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .mem_timeout(mem_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_rd[$];     // expected ROM read addresses, in order
  logic [DW-1:0] exp_spr[$];    // expected spr_data per ack, in order
  bit            m_tag_v = 1'b0;
  logic [AW-1:0] m_tag = '0;
  bit            m_timeout = 1'b0;

  int force_lat = -2;           // -2 random 0..7, -1 never ack, else fixed
  int bursts = 0;
  int last_len = 0;
  int stray_req = 0;
  int stray_done = 0;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 19'h12345) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {5'b00000, a[18:16]} ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ROM responder; also checks each new read address against the model.
  always begin
    @(negedge clk_sys);
    if (stray_req != stray_done) begin
      mem_ack = 1'b1;
      mem_data = 8'h77;
      @(negedge clk_sys);
      mem_ack = 1'b0;
      stray_done++;
    end else if (mem_rd) begin
      logic [AW-1:0] a;
      int lat;
      int len;
      a = mem_addr;
      bursts++;
      if (exp_rd.size() == 0) chk("unexpected_rd", {13'd0, a}, 32'hFFFFFFFF);
      else chk("rd_addr", {13'd0, a}, {13'd0, exp_rd.pop_front()});
      lat = (force_lat == -2) ? int'($urandom_range(0, 7)) : force_lat;
      if (lat >= 0) begin
        for (int i = 0; i < lat; i++) begin
          @(negedge clk_sys);
          chk("rd_stable", {12'd0, mem_rd, a}, {12'd0, 1'b1, mem_addr});
        end
        mem_ack = 1'b1;
        mem_data = mem_val(a);
        @(negedge clk_sys);
        mem_ack = 1'b0;
        mem_data = DW'($urandom);
      end else begin
        len = 0;
        while (mem_rd && len < 100) begin
          len++;
          @(negedge clk_sys);
        end
        last_len = len;
      end
    end
  end

  // Sprite monitor.
  always @(negedge clk_sys) begin
    if (spr_ack) begin
      if (exp_spr.size() == 0) chk("unexpected_spr_ack", 32'd1, 32'd0);
      else chk("spr_data", {24'd0, spr_data}, {24'd0, exp_spr.pop_front()});
    end
  end

  // Background monitor: a hit must present the ROM contents of bg_addr.
  always @(negedge clk_sys) begin
    if (rst_n && bg_valid) chk("bg_data", {24'd0, bg_data}, {24'd0, mem_val(bg_addr)});
  end

  task automatic do_txn(input bit use_bg, input bit use_spr, input logic [AW-1:0] ab,
                        input logic [AW-1:0] as, input bit hold);
    bit got_bg;
    bit got_spr;
    int cyc;
    if (use_bg) begin
      if (!(m_tag_v && m_tag == ab)) exp_rd.push_back(ab);
      m_tag_v = 1'b1;
      m_tag = ab;
    end
    if (use_spr) begin
      exp_rd.push_back(as);
      exp_spr.push_back((force_lat == -1) ? 8'h00 : mem_val(as));
      if (force_lat == -1) m_timeout = 1'b1;
    end
    @(negedge clk_sys);
    bg_addr = ab;
    bg_read = use_bg;
    spr_addr = as;
    spr_req = use_spr;
    got_bg = !use_bg;
    got_spr = !use_spr;
    cyc = 0;
    while (!(got_bg && got_spr) && cyc < 60) begin
      @(negedge clk_sys);
      cyc++;
      if (bg_valid) got_bg = 1'b1;
      if (spr_ack) begin
        got_spr = 1'b1;
        if (!hold) spr_req = 1'b0;
      end
    end
    if (cyc >= 60) chk("txn_timeout", 32'd1, 32'd0);
    if (hold) @(negedge clk_sys);
    spr_req = 1'b0;
    @(negedge clk_sys);
    bg_read = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    int b0;
    logic [AW-1:0] pool [6];
    pool = '{19'h00010, 19'h12345, 19'h40000, 19'h00100, 19'h7FFFF, 19'h2AAAA};

    // Reset values.
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    chk("rst_bg_data", {24'd0, bg_data}, 32'd0);
    chk("rst_spr_data", {24'd0, spr_data}, 32'd0);
    chk("rst_spr_ack", {31'd0, spr_ack}, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);

    // First background fetch: ack k=3 cycles after mem_rd, result after 5 edges.
    force_lat = 3;
    exp_rd.push_back(19'h12345);
    m_tag_v = 1'b1;
    m_tag = 19'h12345;
    @(posedge clk_sys); #1;
    bg_addr = 19'h12345;
    bg_read = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    chk("t1_mem_addr", {13'd0, mem_addr}, 32'h12345);
    repeat (2) @(posedge clk_sys); #1;
    chk("t1_valid_early", {31'd0, bg_valid}, 32'd0);
    @(posedge clk_sys); #1;
    chk("t1_valid", {31'd0, bg_valid}, 32'd1);
    chk("t1_data", {24'd0, bg_data}, 32'hA5);
    // Held on the same address, and re-raised later: served from the tag.
    repeat (5) @(negedge clk_sys);
    chk("t6_bursts_held", bursts, 32'd1);
    bg_read = 1'b0;
    repeat (2) @(negedge clk_sys);
    bg_read = 1'b1;
    @(negedge clk_sys);
    chk("t6_hit_valid", {31'd0, bg_valid}, 32'd1);
    repeat (4) @(negedge clk_sys);
    chk("t6_bursts_hit", bursts, 32'd1);
    bg_read = 1'b0;
    @(negedge clk_sys);

    // Simultaneous requests: background served first, sprite held one extra cycle.
    force_lat = 2;
    b0 = bursts;
    do_txn(1'b1, 1'b1, 19'h00010, 19'h40000, 1'b1);
    chk("t2_bursts", bursts - b0, 32'd2);

    // Address moves during BG_WAIT: first result misses, second read issues.
    force_lat = 4;
    b0 = bursts;
    exp_rd.push_back(19'h00100);
    exp_rd.push_back(19'h00101);
    m_tag_v = 1'b1;
    m_tag = 19'h00101;
    @(negedge clk_sys);
    bg_addr = 19'h00100;
    bg_read = 1'b1;
    for (int i = 0; i < 20 && bursts == b0; i++) @(negedge clk_sys);
    bg_addr = 19'h00101;
    for (int i = 0; i < 30 && bursts < b0 + 2; i++) begin
      @(negedge clk_sys);
      if (bursts < b0 + 2) chk("t3_valid_low", {31'd0, bg_valid}, 32'd0);
    end
    chk("t3_second_rd", bursts - b0, 32'd2);
    for (int i = 0; i < 30 && !bg_valid; i++) @(negedge clk_sys);
    chk("t3_valid", {31'd0, bg_valid}, 32'd1);
    bg_read = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Randomized traffic against the model.
    force_lat = -2;
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      do_txn(kind != 1, kind != 0, pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
             1'($urandom_range(0, 1)));
    end
    chk("rand_no_timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});

    // Ack on the very last allowed cycle wins over the timeout.
    force_lat = 14;
    do_txn(1'b0, 1'b1, 19'h00000, 19'h3C3C3, 1'b0);
    chk("late_ack_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // Sprite timeout: 15 cycles of mem_rd, zero-data ack, sticky flag.
    force_lat = -1;
    do_txn(1'b0, 1'b1, 19'h00000, 19'h2AAAA, 1'b0);
    chk("to_len", last_len, 32'd15);
    chk("to_flag", {31'd0, mem_timeout}, {31'd0, m_timeout});
    chk("to_mem_rd", {31'd0, mem_rd}, 32'd0);
    force_lat = -2;
    do_txn(1'b1, 1'b0, 19'h11111, 19'h00000, 1'b0);
    chk("to_sticky", {31'd0, mem_timeout}, 32'd1);

    // Reset mid BG_WAIT, then a stray ack.
    force_lat = -1;
    exp_rd.push_back(19'h05555);
    b0 = bursts;
    @(negedge clk_sys);
    bg_addr = 19'h05555;
    bg_read = 1'b1;
    for (int i = 0; i < 20 && bursts == b0; i++) @(negedge clk_sys);
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b0;
    bg_read = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    m_tag_v = 1'b0;
    m_timeout = 1'b0;
    stray_req++;
    repeat (3) @(negedge clk_sys);
    chk("rr_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rr_mem_addr", {13'd0, mem_addr}, 32'd0);
    chk("rr_bg_data", {24'd0, bg_data}, 32'd0);
    chk("rr_spr_data", {24'd0, spr_data}, 32'd0);
    chk("rr_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("rr_bursts", bursts - b0, 32'd1);
    bg_read = 1'b1;
    #1;
    chk("rr_bg_valid", {31'd0, bg_valid}, 32'd0);
    bg_read = 1'b0;
    repeat (3) @(negedge clk_sys);

    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    chk("spr_queue_empty", exp_spr.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
